// File: rtl/iq_deinterleaver.sv
// iq_deinterleaver: pairs interleaved I/Q words per channel, optional offset-binary conversion, buffered output FIFO.
module iq_deinterleaver #(
  parameter int DATA_W = 16,
  parameter int CHANNELS = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic              M100CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              q_first,
  input  logic              offset_bin,
  input  logic              resync,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              drop_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * DATA_W + CH_W;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
  typedef enum logic {FIRST, SECOND} phase_t;
  phase_t phase_q, phase_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [DATA_W-1:0] held_q, held_d, w0, w1;
  logic qf_q, qf_d, ob_q, ob_d, drop_q, drop_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic accept, push, pop, start;
  assign in_ready = cnt_q != FULL;
  assign out_valid = cnt_q != '0;
  assign accept = in_valid & in_ready;
  assign start = accept & (resync | phase_q == FIRST);
  assign push = accept & ~resync & phase_q == SECOND;
  assign pop = out_valid & out_ready;
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  // Conversion uses the mode latched with the first word so the whole pair is consistent
  assign w0 = {held_q[DATA_W-1] ^ ob_q, held_q[DATA_W-2:0]};
  assign w1 = {data_in[DATA_W-1] ^ ob_q, data_in[DATA_W-2:0]};
  assign head = mem_q[rd_q];
  assign out_i = out_valid ? head[EW-1 -: DATA_W] : '0;
  assign out_q = out_valid ? head[CH_W +: DATA_W] : '0;
  assign out_ch = out_valid ? head[CH_W-1:0] : '0;
  assign drop_err = drop_q;
  always_comb begin
    phase_d = start ? SECOND : (push | resync) ? FIRST : phase_q;
    ch_d = resync ? '0 : push ? (ch_q == LAST_CH ? '0 : ch_q + 1'b1) : ch_q;
    held_d = start ? data_in : held_q;
    qf_d = start ? q_first : qf_q;
    ob_d = start ? offset_bin : ob_q;
    drop_d = drop_q | (resync & phase_q == SECOND);
  end
  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      phase_q <= FIRST;
      ch_q <= '0;
      held_q <= '0;
      qf_q <= 1'b0;
      ob_q <= 1'b0;
      drop_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      phase_q <= phase_d;
      ch_q <= ch_d;
      held_q <= held_d;
      qf_q <= qf_d;
      ob_q <= ob_d;
      drop_q <= drop_d;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge M100CLK) begin
    if (push) mem_q[wr_q] <= {qf_q ? w1 : w0, qf_q ? w0 : w1, ch_q};
  end
endmodule

// File: tb/tb_iq_deinterleaver.sv
// tb_iq_deinterleaver: table vectors, directed corner sequences and randomized traffic against a queue-based reference model.
module tb_iq_deinterleaver;
  localparam int CHN = 2;
  localparam int FD = 4;
  logic clk = 0, rst = 1;
  logic [15:0] data_in = '0;
  logic in_valid = 0, q_first = 0, offset_bin = 0, resync = 0, out_ready = 0;
  logic in_ready, out_valid, drop_err;
  logic [15:0] out_i, out_q;
  logic [0:0] out_ch;
  int checks = 0, errors = 0;

  iq_deinterleaver #(.DATA_W(16), .CHANNELS(CHN), .FIFO_DEPTH(FD)) dut (
    .M100CLK(clk), .reset(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .q_first(q_first), .offset_bin(offset_bin), .resync(resync), .out_i(out_i), .out_q(out_q),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready), .drop_err(drop_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {logic [15:0] d; bit qf; bit ob;} word_t;
  typedef struct {logic [15:0] i; logic [15:0] q; int ch;} pair_t;
  word_t pend[$];
  pair_t expq[$];
  int npairs = 0, npop = 0;
  bit mdrop = 0, stall = 0, rdy, acc;
  word_t fw;
  pair_t np;
  logic [15:0] prev_i, prev_q;
  logic [0:0] prev_ch;

  function automatic logic [15:0] conv(input logic [15:0] x, input bit ob);
    return ob ? 16'(x - 16'h8000) : x;
  endfunction

  // Reference: words accumulate in a pending list; every two form a pair numbered since last resync.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expq.delete(); pend.delete(); npairs = 0; mdrop = 0; stall = 0;
    end else begin
      rdy = expq.size() < FD;
      acc = in_valid && rdy;
      stall = expq.size() != 0 && !out_ready;
      if (out_ready && expq.size() != 0) begin void'(expq.pop_front()); npop++; end
      if (resync) begin
        if (pend.size() == 1) mdrop = 1;
        pend.delete(); npairs = 0;
      end
      if (acc) begin
        if (pend.size() == 0) pend.push_back('{data_in, q_first, offset_bin});
        else begin
          fw = pend[0];
          np.q = fw.qf ? conv(fw.d, fw.ob) : conv(data_in, fw.ob);
          np.i = fw.qf ? conv(data_in, fw.ob) : conv(fw.d, fw.ob);
          np.ch = npairs % CHN;
          npairs++;
          expq.push_back(np);
          pend.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_valid", 32'(out_valid), 32'(expq.size() != 0));
      chk("m_ready", 32'(in_ready), 32'(expq.size() < FD));
      chk("m_drop", 32'(drop_err), 32'(mdrop));
      if (expq.size() != 0) begin
        chk("m_i", 32'(out_i), 32'(expq[0].i));
        chk("m_q", 32'(out_q), 32'(expq[0].q));
        chk("m_ch", 32'(out_ch), 32'(expq[0].ch));
      end
      if (stall) begin
        chk("stable_i", 32'(out_i), 32'(prev_i));
        chk("stable_q", 32'(out_q), 32'(prev_q));
        chk("stable_ch", 32'(out_ch), 32'(prev_ch));
      end
      prev_i = out_i; prev_q = out_q; prev_ch = out_ch;
    end
  end

  task automatic word(input logic [15:0] d, input bit qf, input bit ob, input bit rs);
    data_in = d; q_first = qf; offset_bin = ob; resync = rs; in_valid = 1;
    @(negedge clk);
    in_valid = 0; resync = 0;
  endtask

  task automatic send(input logic [15:0] d);
    bit ok = 0;
    data_in = d; in_valid = 1;
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = in_ready;
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  typedef struct {logic [15:0] w0; logic [15:0] w1; bit qf; bit ob; int gap;
                  logic [15:0] ei; logic [15:0] eq; logic [0:0] ech;} vec_t;
  vec_t tbl[4];
  int base;

  initial begin
    tbl[0] = '{16'h8001, 16'h7FFF, 1'b1, 1'b1, 0, 16'hFFFF, 16'h0001, 1'b0};
    tbl[1] = '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 0, 16'h7FFF, 16'h8000, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 0, 16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{16'h1234, 16'hABCD, 1'b0, 1'b0, 3, 16'h1234, 16'hABCD, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_drop", 32'(drop_err), 0);
    chk("rst_i", 32'(out_i), 0);
    chk("rst_ch", 32'(out_ch), 0);
    rst = 0;
    @(negedge clk);
    // Mode inputs flip on the second word to show they are latched per pair
    for (int k = 0; k < 4; k++) begin
      word(tbl[k].w0, tbl[k].qf, tbl[k].ob, 0);
      for (int g = 0; g < tbl[k].gap; g++) begin
        chk("tbl_gap_valid", 32'(out_valid), 0);
        @(negedge clk);
      end
      word(tbl[k].w1, !tbl[k].qf, !tbl[k].ob, 0);
      chk("tbl_valid", 32'(out_valid), 1);
      chk("tbl_i", 32'(out_i), 32'(tbl[k].ei));
      chk("tbl_q", 32'(out_q), 32'(tbl[k].eq));
      chk("tbl_ch", 32'(out_ch), 32'(tbl[k].ech));
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
    end
    q_first = 0; offset_bin = 0;
    for (int p = 0; p < 4; p++) begin
      send(16'(2 * p)); send(16'(2 * p + 1));
    end
    chk("full_ready", 32'(in_ready), 0);
    fork
      begin send(16'h0008); send(16'h0009); end
      begin
        repeat (3) @(negedge clk);
        chk("held_ready", 32'(in_ready), 0);
        base = npop;
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
          chk("drain_valid", 32'(out_valid), 1);
          @(negedge clk);
        end
        chk("drain_empty", 32'(out_valid), 0);
        chk("drain_count", 32'(npop - base), 5);
      end
    join
    word(16'h1111, 0, 0, 0);
    resync = 1;
    @(negedge clk);
    resync = 0;
    chk("resync_drop", 32'(drop_err), 1);
    word(16'h2222, 0, 0, 0); word(16'h3333, 0, 0, 0);
    chk("resync_valid", 32'(out_valid), 1);
    chk("resync_ch", 32'(out_ch), 0);
    chk("resync_i", 32'(out_i), 32'h2222);
    chk("resync_q", 32'(out_q), 32'h3333);
    rst = 1;
    @(negedge clk);
    rst = 0;
    word(16'h4444, 0, 0, 0); word(16'h5555, 0, 0, 0);
    word(16'h6666, 0, 0, 1); word(16'h7777, 0, 0, 0);
    chk("rsv_ch", 32'(out_ch), 0);
    chk("rsv_i", 32'(out_i), 32'h6666);
    chk("rsv_drop", 32'(drop_err), 0);
    @(negedge clk);
    out_ready = 0;
    for (int k = 0; k < 7; k++) word(16'(16'h0100 + k), 1, 0, 0);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_i", 32'(out_i), 0);
    chk("arst_q", 32'(out_q), 0);
    chk("arst_ch", 32'(out_ch), 0);
    chk("arst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 0);
    word(16'hAAAA, 0, 0, 0); word(16'hBBBB, 0, 0, 0);
    chk("post_rst_pair", 32'(out_valid), 1);
    chk("post_rst_ch", 32'(out_ch), 0);
    chk("post_rst_i", 32'(out_i), 32'hAAAA);
    for (int k = 0; k < 600; k++) begin
      in_valid = $urandom_range(0, 3) != 0;
      data_in = 16'($urandom);
      q_first = 1'($urandom);
      offset_bin = 1'($urandom);
      resync = $urandom_range(0, 19) == 0;
      out_ready = k < 300 ? ~out_ready : ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid = 0; resync = 0; out_ready = 1;
    repeat (10) @(negedge clk);
    chk("final_empty", 32'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
